// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter that owns the select lines of a shared 4-to-1 mux. Four
// requesters compete for the mux; at most one is routed to the mux output at a
// time. A hold limit bounds how long an owner keeps the mux while another
// requester is waiting.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles for one owner under contention (1..255)
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-high
//   req   in   [3:0] request levels, req[0..3] -> mux inputs a..d
//   gnt   out  [3:0] one-hot grant, registered, zero when idle
//   s0    out  mux select MSB of owner index, registered
//   s1    out  mux select LSB of owner index, registered
//   busy  out  registered, high whenever gnt is non-zero
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy
);

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  // Counter value at which a contended owner must hand the mux over.
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_e     state_q;
  logic [1:0] last_q;
  logic [7:0] cnt_q;
  logic [3:0] gnt_q;
  logic       s0_q;
  logic       s1_q;
  logic       busy_q;

  // First set bit of vec at or after start, wrapping modulo 4. Callers only
  // use the result when vec is non-zero.
  function automatic logic [1:0] rr_pick(input logic [3:0] vec, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [1:0] owner;
  logic       own_req;
  logic [3:0] others;
  logic [1:0] pick_idle;
  logic [1:0] pick_hand;
  logic       contended;
  logic       hold_done;

  always_comb begin
    owner     = {s0_q, s1_q};
    own_req   = req[owner];
    others    = req & ~(4'b0001 << owner);
    contended = |others;
    hold_done = (cnt_q == HoldLast);
    // Idle search starts just past the previous owner.
    pick_idle = rr_pick(req, last_q + 2'd1);
    // Handoff search excludes the current owner and starts just past it.
    pick_hand = rr_pick(others, owner + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q      <= StGrant;
            last_q       <= pick_idle;
            cnt_q        <= 8'd0;
            gnt_q        <= 4'b0001 << pick_idle;
            {s0_q, s1_q} <= pick_idle;
            busy_q       <= 1'b1;
          end
          // No request: outputs stay zero, selects keep their last value.
        end

        StGrant: begin
          if ((!own_req && contended) || (own_req && hold_done && contended)) begin
            // Same-edge handoff: no idle bubble between owners.
            last_q       <= pick_hand;
            cnt_q        <= 8'd0;
            gnt_q        <= 4'b0001 << pick_hand;
            {s0_q, s1_q} <= pick_hand;
          end else if (!own_req) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
          end else if (!hold_done) begin
            // Saturates at HoldLast so a later contender preempts promptly.
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: begin
          state_q <= StIdle;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign s0   = s0_q;
  assign s1   = s1_q;
  assign busy = busy_q;

  // Structural invariants of the registered outputs.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_busy_match  : assert property (@(posedge clk) disable iff (rst) busy_q == (|gnt_q));
  a_sel_match   : assert property (@(posedge clk) disable iff (rst)
                                   busy_q |-> gnt_q == (4'b0001 << {s0_q, s1_q}));

endmodule
